// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation ADC controller:
// FSM state type and default resolution / DAC settling parameters.
package sar_pkg;

  localparam int unsigned DEF_BITS   = 8;
  localparam int unsigned DEF_SETTLE = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_TRIAL  = 2'd2,
    S_DONE   = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: sample, then binary-search the DAC code MSB-first,
// holding each trial code for SETTLE+1 cycles before reading the comparator.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned BITS   = DEF_BITS,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            cmp,
  output logic            sample,
  output logic [BITS-1:0] dac,
  output logic            busy,
  output logic            valid,
  output logic [BITS-1:0] result
);

  localparam int unsigned IW = (BITS > 1) ? $clog2(BITS) : 1;

  sar_state_t      state;
  logic [BITS-1:0] code;
  logic [BITS-1:0] next_code;
  logic [IW-1:0]   bitidx;
  logic [31:0]     bi;
  logic [3:0]      cnt;

  assign bi = 32'(bitidx);

  // Decide the current bit from cmp and tentatively set the next lower bit.
  always_comb begin
    next_code = code;
    for (int unsigned b = 0; b < BITS; b++) begin
      if (b == bi) begin
        next_code[b] = cmp;
      end else if (b + 1 == bi) begin
        next_code[b] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      code   <= '0;
      bitidx <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            state            <= S_TRIAL;
            code             <= '0;
            code[BITS-1]     <= 1'b1;
            bitidx           <= IW'(BITS - 1);
            cnt              <= 4'(SETTLE);
          end
        end
        S_TRIAL: begin
          // abort outranks the final-bit decision, so result stays untouched
          if (abort) begin
            state <= S_IDLE;
            code  <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            code <= next_code;
            if (bitidx == '0) begin
              state  <= S_DONE;
              result <= next_code;
            end else begin
              bitidx <= bitidx - 1'b1;
              cnt    <= 4'(SETTLE);
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          code  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sample = (state == S_SAMPLE);
  assign busy   = (state != S_IDLE);
  assign valid  = (state == S_DONE);
  assign dac    = (state == S_TRIAL) ? code : '0;

endmodule
